can_rx_brs_ctrl: RTL and testbench



---
 rtl/can_fd_pkg.sv | 57 +++++
 rtl/can_rx_brs_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_can_rx_brs_ctrl.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/can_fd_pkg.sv
// -----------------------------------------------------------------------------
// can_fd_pkg
// Shared definitions for the CAN FD receive-side bit-rate-switch controller:
//   - rx_state_e     : field tracker states
//   - field lengths  : bit counts of the multi-bit arbitration/control/CRC fields
//   - CRC_SEL_BYTES  : payloads up to this many bytes use the 17-bit CRC
//   - CNT_MAX        : saturation value of the field bit counter
//   - dlc_to_bytes() : CAN FD DLC code to payload byte count
// -----------------------------------------------------------------------------
package can_fd_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_BASEID,
    ST_SRRRRS,
    ST_IDE,
    ST_EXTID,
    ST_RRS,
    ST_FDF,
    ST_RES,
    ST_BRS,
    ST_ESI,
    ST_DLC,
    ST_DATA,
    ST_SBC,
    ST_CRC,
    ST_DELIM,
    ST_CLASSIC
  } rx_state_e;

  localparam int BASEID_LEN    = 11;
  localparam int EXTID_LEN     = 18;
  localparam int DLC_LEN       = 4;
  localparam int SBC_LEN       = 4;
  localparam int CRC17_LEN     = 17;
  localparam int CRC21_LEN     = 21;
  localparam int CRC_SEL_BYTES = 16;

  // Longest field is 64 bytes of data (512 bits): the counter tops out at 511.
  localparam int CNT_MAX       = 511;

  function automatic logic [6:0] dlc_to_bytes(input logic [3:0] dlc);
    logic [6:0] nbytes;
    case (dlc)
      4'd9:    nbytes = 7'd12;
      4'd10:   nbytes = 7'd16;
      4'd11:   nbytes = 7'd20;
      4'd12:   nbytes = 7'd24;
      4'd13:   nbytes = 7'd32;
      4'd14:   nbytes = 7'd48;
      4'd15:   nbytes = 7'd64;
      default: nbytes = {3'b000, dlc};
    endcase
    return nbytes;
  endfunction

endpackage

// File: rtl/can_rx_brs_ctrl.sv
// -----------------------------------------------------------------------------
// can_rx_brs_ctrl
// Receive-side CAN FD bit-rate-switch controller. Follows the destuffed bit
// stream field by field, detects FDF/BRS and chooses which sample-point strobe
// feeds the receiver. Data-phase timing is selected one clock after a
// recessive BRS bit and dropped one clock after the CRC delimiter bit.
//
// Optional build macro: RX_BRS_ESI_CAPTURE_EN adds the esiFlag output, which
// holds the ESI bit of the current frame.
//
// Ports:
//   clk            in   system clock
//   rst_n          in   asynchronous active-low reset
//   samplePoint    in   nominal-phase sample strobe (1-cycle pulse)
//   samplePointFD  in   data-phase sample strobe (1-cycle pulse)
//   sof            in   start of frame / hard sync (1-cycle pulse)
//   rxBit          in   destuffed received bit (1 = recessive)
//   bitValid       in   rxBit strobe (never asserted for stuff bits)
//   abort          in   error frame / bus-off / idle, forces nominal timing
//   samplePointOUT out  selected sample strobe (combinational)
//   brsActive      out  data-phase timing selected
//   fdFrame        out  current frame is an FD frame
//   dataBytes      out  payload length decoded from DLC
//   esiFlag        out  captured ESI bit (RX_BRS_ESI_CAPTURE_EN only)
// -----------------------------------------------------------------------------
module can_rx_brs_ctrl
  import can_fd_pkg::*;
#(
  parameter int CNT_W = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       samplePoint,
  input  logic       samplePointFD,
  input  logic       sof,
  input  logic       rxBit,
  input  logic       bitValid,
  input  logic       abort,
  output logic       samplePointOUT,
  output logic       brsActive,
  output logic       fdFrame,
  output logic [6:0] dataBytes
`ifdef RX_BRS_ESI_CAPTURE_EN
  ,
  output logic       esiFlag
`endif
);

  rx_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic [2:0]       dlc_sr, dlc_sr_nxt;
  logic [3:0]       dlc_full;
  logic             brs_nxt;
  logic             fd_nxt;
  logic [6:0]       bytes_nxt;
  logic [9:0]       data_bits;
  logic [CNT_W-1:0] data_last;
  logic [CNT_W-1:0] crc_last;
`ifdef RX_BRS_ESI_CAPTURE_EN
  logic             esi_nxt;
`endif

  // The strobe mux is deliberately unregistered so the receiver sees the
  // selected sample point in the same cycle it is generated.
  assign samplePointOUT = brsActive ? samplePointFD : samplePoint;

  // Counter saturates instead of wrapping so a malformed frame can never
  // alias back onto a short field length.
  assign cnt_inc   = (cnt == CNT_W'(CNT_MAX)) ? cnt : cnt + 1'b1;

  assign data_bits = {dataBytes, 3'b000};
  assign data_last = CNT_W'(data_bits - 10'd1);
  assign crc_last  = (dataBytes <= 7'(CRC_SEL_BYTES)) ? CNT_W'(CRC17_LEN - 1)
                                                      : CNT_W'(CRC21_LEN - 1);

  // DLC arrives MSB first; the 4th bit completes the code combinationally.
  assign dlc_full  = {dlc_sr, rxBit};

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    dlc_sr_nxt = dlc_sr;
    brs_nxt    = brsActive;
    fd_nxt     = fdFrame;
    bytes_nxt  = dataBytes;
`ifdef RX_BRS_ESI_CAPTURE_EN
    esi_nxt    = esiFlag;
`endif

    if (abort) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
      brs_nxt   = 1'b0;
      fd_nxt    = 1'b0;
`ifdef RX_BRS_ESI_CAPTURE_EN
      esi_nxt   = 1'b0;
`endif
    end else if (sof) begin
      // A restart from any state, including mid-frame, lands at the first
      // identifier bit with nominal timing.
      state_nxt = ST_BASEID;
      cnt_nxt   = '0;
      brs_nxt   = 1'b0;
      fd_nxt    = 1'b0;
`ifdef RX_BRS_ESI_CAPTURE_EN
      esi_nxt   = 1'b0;
`endif
    end else if (bitValid) begin
      case (state)
        ST_IDLE: ;
        ST_BASEID: begin
          cnt_nxt = cnt_inc;
          if (cnt == CNT_W'(BASEID_LEN - 1)) state_nxt = ST_SRRRRS;
        end
        ST_SRRRRS: state_nxt = ST_IDE;
        ST_IDE:    state_nxt = rxBit ? ST_EXTID : ST_FDF;
        ST_EXTID: begin
          cnt_nxt = cnt_inc;
          if (cnt == CNT_W'(EXTID_LEN - 1)) state_nxt = ST_RRS;
        end
        ST_RRS:    state_nxt = ST_FDF;
        ST_FDF: begin
          if (rxBit) begin
            state_nxt = ST_RES;
            fd_nxt    = 1'b1;
          end else begin
            state_nxt = ST_CLASSIC;
          end
        end
        // A recessive res bit is a protocol exception: stop tracking and
        // stay on nominal timing for the rest of the frame.
        ST_RES:    state_nxt = rxBit ? ST_CLASSIC : ST_BRS;
        ST_BRS: begin
          state_nxt = ST_ESI;
          if (rxBit) brs_nxt = 1'b1;
        end
        ST_ESI: begin
          state_nxt = ST_DLC;
`ifdef RX_BRS_ESI_CAPTURE_EN
          esi_nxt   = rxBit;
`endif
        end
        ST_DLC: begin
          cnt_nxt    = cnt_inc;
          dlc_sr_nxt = dlc_full[2:0];
          if (cnt == CNT_W'(DLC_LEN - 1)) begin
            bytes_nxt = dlc_to_bytes(dlc_full);
            state_nxt = (dlc_full == 4'd0) ? ST_SBC : ST_DATA;
          end
        end
        ST_DATA: begin
          cnt_nxt = cnt_inc;
          if (cnt == data_last) state_nxt = ST_SBC;
        end
        ST_SBC: begin
          cnt_nxt = cnt_inc;
          if (cnt == CNT_W'(SBC_LEN - 1)) state_nxt = ST_CRC;
        end
        ST_CRC: begin
          cnt_nxt = cnt_inc;
          if (cnt == crc_last) state_nxt = ST_DELIM;
        end
        ST_DELIM: begin
          state_nxt = ST_CLASSIC;
          brs_nxt   = 1'b0;
        end
        ST_CLASSIC: ;
        default:   state_nxt = ST_IDLE;
      endcase
      if (state_nxt != state) cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      dlc_sr    <= '0;
      brsActive <= 1'b0;
      fdFrame   <= 1'b0;
      dataBytes <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      dlc_sr    <= dlc_sr_nxt;
      brsActive <= brs_nxt;
      fdFrame   <= fd_nxt;
      dataBytes <= bytes_nxt;
    end
  end

`ifdef RX_BRS_ESI_CAPTURE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) esiFlag <= 1'b0;
    else        esiFlag <= esi_nxt;
  end
`endif

endmodule

// File: tb/tb_can_rx_brs_ctrl.sv
// -----------------------------------------------------------------------------
// tb_can_rx_brs_ctrl
// Directed and randomized frames for can_rx_brs_ctrl. Each frame is built as a
// list of destuffed bits; the expected outputs follow from the bit positions of
// FDF, BRS, ESI, the last DLC bit and the CRC delimiter within that list.
// -----------------------------------------------------------------------------
module tb_can_rx_brs_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       samplePoint;
  logic       samplePointFD;
  logic       sof;
  logic       rxBit;
  logic       bitValid;
  logic       abort;
  logic       samplePointOUT;
  logic       brsActive;
  logic       fdFrame;
  logic [6:0] dataBytes;
`ifdef RX_BRS_ESI_CAPTURE_EN
  logic       esiFlag;
`endif

  can_rx_brs_ctrl #(.CNT_W(10)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .samplePoint    (samplePoint),
    .samplePointFD  (samplePointFD),
    .sof            (sof),
    .rxBit          (rxBit),
    .bitValid       (bitValid),
    .abort          (abort),
    .samplePointOUT (samplePointOUT),
    .brsActive      (brsActive),
    .fdFrame        (fdFrame),
    .dataBytes      (dataBytes)
`ifdef RX_BRS_ESI_CAPTURE_EN
    ,
    .esiFlag        (esiFlag)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  bit frame_q[$];
  int idx_fdf, idx_brs, idx_esi, idx_dlc, idx_delim;
  int frame_bytes;

  bit exp_brs, exp_fd, exp_esi;
  int exp_bytes;

  int bytes_tbl[16] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 12, 16, 20, 24, 32, 48, 64};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string where);
    chk({where, ".brsActive"}, brsActive, exp_brs);
    chk({where, ".fdFrame"},   fdFrame,   exp_fd);
    chk({where, ".dataBytes"}, dataBytes, exp_bytes);
`ifdef RX_BRS_ESI_CAPTURE_EN
    chk({where, ".esiFlag"},   esiFlag,   exp_esi);
`endif
  endtask

  task automatic clear_idx();
    idx_fdf = -1; idx_brs = -1; idx_esi = -1; idx_dlc = -1; idx_delim = -1;
  endtask

  task automatic push_rand(input int n);
    for (int k = 0; k < n; k++) frame_q.push_back(bit'($urandom_range(0, 1)));
  endtask

  // Bit list of one frame from SOF+1 onwards, plus trailing bits that the
  // controller must ignore once it has left the tracked fields.
  task automatic build_frame(input bit ide, input bit fdf, input bit res,
                             input bit brs, input bit esi, input int dlc);
    frame_q.delete();
    clear_idx();
    frame_bytes = bytes_tbl[dlc];
    push_rand(11);
    frame_q.push_back(1'b1);
    frame_q.push_back(ide);
    if (ide) push_rand(19);
    idx_fdf = frame_q.size();
    frame_q.push_back(fdf);
    if (fdf) begin
      frame_q.push_back(res);
      if (!res) begin
        idx_brs = frame_q.size();
        frame_q.push_back(brs);
        idx_esi = frame_q.size();
        frame_q.push_back(esi);
        for (int k = 3; k >= 0; k--) frame_q.push_back(bit'((dlc >> k) & 1));
        idx_dlc = frame_q.size() - 1;
        push_rand(frame_bytes * 8);
        push_rand(4);
        push_rand(frame_bytes <= 16 ? 17 : 21);
        idx_delim = frame_q.size();
        frame_q.push_back(1'b1);
      end
    end
    push_rand(12);
  endtask

  task automatic strobe_and_check_mux(input string tag);
    samplePoint   = 1'($urandom_range(0, 1));
    samplePointFD = 1'($urandom_range(0, 1));
    #1;
    chk(tag, samplePointOUT, exp_brs ? samplePointFD : samplePoint);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    strobe_and_check_mux("mux_idle");
    @(posedge clk);
    #1;
    samplePoint = 1'b0;
    samplePointFD = 1'b0;
  endtask

  task automatic send_bit(input bit b, input int i);
    @(negedge clk);
    bitValid = 1'b1;
    rxBit    = b;
    strobe_and_check_mux("mux_bit");
    @(posedge clk);
    #1;
    bitValid = 1'b0;
    samplePoint = 1'b0;
    samplePointFD = 1'b0;
    if (i == idx_fdf && b) exp_fd = 1'b1;
    if (i == idx_brs && b) exp_brs = 1'b1;
    if (i == idx_esi)      exp_esi = b;
    if (i == idx_dlc)      exp_bytes = frame_bytes;
    if (i == idx_delim)    exp_brs = 1'b0;
    check_outs("bit");
  endtask

  task automatic run_bits(input int from, input int upto);
    for (int i = from; i < upto; i++) begin
      if ($urandom_range(0, 3) == 0) idle_cycle();
      send_bit(frame_q[i], i);
    end
  endtask

  task automatic do_sof(input bit with_bit, input bit b);
    @(negedge clk);
    sof      = 1'b1;
    bitValid = with_bit;
    rxBit    = b;
    @(posedge clk);
    #1;
    sof      = 1'b0;
    bitValid = 1'b0;
    exp_brs  = 1'b0;
    exp_fd   = 1'b0;
    exp_esi  = 1'b0;
    check_outs("sof");
  endtask

  task automatic full_frame(input bit ide, input bit fdf, input bit res,
                            input bit brs, input bit esi, input int dlc);
    build_frame(ide, fdf, res, brs, esi, dlc);
    do_sof(1'b0, 1'b0);
    run_bits(0, frame_q.size());
  endtask

  initial begin
    rst_n = 1'b0; samplePoint = 1'b0; samplePointFD = 1'b0; sof = 1'b0;
    rxBit = 1'b0; bitValid = 1'b0; abort = 1'b0;
    exp_brs = 1'b0; exp_fd = 1'b0; exp_esi = 1'b0; exp_bytes = 0;
    clear_idx();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_outs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycle();

    // Base-ID FD frame, BRS=1, DLC=2
    full_frame(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2);
    chk("fd_dlc2_bytes", dataBytes, 2);

    // Extended FD frame, BRS=1, DLC=15 (512 data bits, CRC21)
    full_frame(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 15);
    chk("ext_dlc15_bytes", dataBytes, 64);

    // Classic frame
    full_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("classic_fd", fdFrame, 0);

    // FD frame with BRS=0, DLC=9
    full_frame(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9);
    chk("nobrs_fd", fdFrame, 1);
    chk("nobrs_bytes", dataBytes, 12);

    // Protocol exception (res=1)
    full_frame(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0);

    // Abort during DATA with data-phase timing active
    build_frame(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8);
    do_sof(1'b0, 1'b0);
    run_bits(0, idx_dlc + 20);
    chk("pre_abort_brs", brsActive, 1);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    exp_brs = 1'b0; exp_fd = 1'b0; exp_esi = 1'b0;
    check_outs("abort");
    clear_idx();
    for (int i = 0; i < 40; i++) send_bit(1'b1, i);
    full_frame(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3);

    // sof together with a recessive bitValid in the BRS field
    build_frame(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4);
    do_sof(1'b0, 1'b0);
    run_bits(0, idx_brs);
    do_sof(1'b1, 1'b1);
    chk("sof_vs_brs", brsActive, 0);
    build_frame(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5);
    run_bits(0, frame_q.size());

    // Asynchronous reset mid-DATA
    build_frame(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 10);
    do_sof(1'b0, 1'b0);
    run_bits(0, idx_dlc + 30);
    #2;
    rst_n = 1'b0;
    #1;
    exp_brs = 1'b0; exp_fd = 1'b0; exp_esi = 1'b0; exp_bytes = 0;
    check_outs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    clear_idx();
    for (int i = 0; i < 10; i++) send_bit(1'b0, i);

    // Randomized frames
    for (int f = 0; f < 25; f++) begin
      full_frame(bit'($urandom_range(0, 1)),
                 bit'($urandom_range(0, 5) != 0),
                 bit'($urandom_range(0, 7) == 0),
                 bit'($urandom_range(0, 1)),
                 bit'($urandom_range(0, 1)),
                 int'($urandom_range(0, 15)));
      if ($urandom_range(0, 4) == 0) idle_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
